// File: rtl/rom_loader.sv
// Serial ROM loader: receives a framed word image, writes it into the HACK ROM and answers ACK/NAK.
// Optional trailing checksum byte is enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
    parameter int         TIMEOUT_CYCLES = 50000000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    output logic [14:0] ROMAddressLineCtl,
    output logic [15:0] ROMDataLine,
    output logic        ROMLoad,
    output logic        cpu_rst,
    output logic        loaded,
    output logic        load_err
);

    localparam int         GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam logic [15:0] MAX_WORDS = 16'd32768;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DAT_HI,
        S_DAT_LO,
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_RESP
    } state_t;

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHK;
`else
    localparam state_t S_END = S_RESP;
`endif

    state_t      state_q, state_d;
    logic [GAP_W-1:0] gap_q;
    logic [7:0]  cnt_hi_q;
    logic [15:0] rem_q;
    logic [7:0]  dat_hi_q;
    logic [14:0] addr_q;
    logic        nak_q;
    logic [7:0]  tx_data_q;
    logic        new_tx_q;
    logic [14:0] rom_addr_q;
    logic [15:0] rom_data_q;
    logic        rom_load_q;
    logic        cpu_rst_q;
    logic        loaded_q;
    logic        load_err_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q;
`endif

    logic        in_frame_w;
    logic        timeout_w;
    logic        accept_w;
    logic [15:0] count_w;

    // Timeout has priority over a coincident byte, which is then dropped.
    assign timeout_w = in_frame_w && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
    assign accept_w  = new_rx_data && !timeout_w && (state_q != S_RESP);
    assign count_w   = {cnt_hi_q, rx_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_w && rx_data == SYNC_BYTE) state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (timeout_w)     state_d = S_RESP;
                else if (accept_w) state_d = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (timeout_w) begin
                    state_d = S_RESP;
                end else if (accept_w) begin
                    if (count_w == 16'd0)          state_d = S_END;
                    else if (count_w > MAX_WORDS)  state_d = S_RESP;
                    else                           state_d = S_DAT_HI;
                end
            end
            S_DAT_HI: begin
                if (timeout_w)     state_d = S_RESP;
                else if (accept_w) state_d = S_DAT_LO;
            end
            S_DAT_LO: begin
                if (timeout_w)     state_d = S_RESP;
                else if (accept_w) state_d = (rem_q == 16'd1) ? S_END : S_DAT_HI;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (timeout_w || accept_w) state_d = S_RESP;
            end
`endif
            S_RESP: begin
                if (!tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic frame_start_w;
    logic lat_cnt_hi_w;
    logic lat_cnt_lo_w;
    logic lat_dat_hi_w;
    logic wr_word_w;
    logic add_sum_w;
    logic nak_set_w;
    logic resp_fire_w;

    always_comb begin
        in_frame_w    = 1'b0;
        frame_start_w = 1'b0;
        lat_cnt_hi_w  = 1'b0;
        lat_cnt_lo_w  = 1'b0;
        lat_dat_hi_w  = 1'b0;
        wr_word_w     = 1'b0;
        add_sum_w     = 1'b0;
        nak_set_w     = 1'b0;
        resp_fire_w   = 1'b0;
        case (state_q)
            S_IDLE: begin
                frame_start_w = accept_w && (rx_data == SYNC_BYTE);
            end
            S_CNT_HI: begin
                in_frame_w   = 1'b1;
                lat_cnt_hi_w = accept_w;
                add_sum_w    = accept_w;
            end
            S_CNT_LO: begin
                in_frame_w   = 1'b1;
                lat_cnt_lo_w = accept_w;
                add_sum_w    = accept_w;
            end
            S_DAT_HI: begin
                in_frame_w   = 1'b1;
                lat_dat_hi_w = accept_w;
                add_sum_w    = accept_w;
            end
            S_DAT_LO: begin
                in_frame_w = 1'b1;
                wr_word_w  = accept_w;
                add_sum_w  = accept_w;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_frame_w = 1'b1;
            end
`endif
            S_RESP: begin
                resp_fire_w = !tx_busy;
            end
            default: ;
        endcase
        // Any abnormal frame end: timeout, oversized count, or bad checksum.
        if (timeout_w) nak_set_w = 1'b1;
        if (lat_cnt_lo_w && count_w > MAX_WORDS) nak_set_w = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
        if (state_q == S_CHK && accept_w && rx_data != sum_q) nak_set_w = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q      <= '0;
            cnt_hi_q   <= '0;
            rem_q      <= '0;
            dat_hi_q   <= '0;
            addr_q     <= '0;
            nak_q      <= 1'b0;
            tx_data_q  <= '0;
            new_tx_q   <= 1'b0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            rom_load_q <= 1'b0;
            cpu_rst_q  <= 1'b0;
            loaded_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            if (!in_frame_w || accept_w || timeout_w) gap_q <= '0;
            else                                      gap_q <= gap_q + GAP_W'(1);

            if (lat_cnt_hi_w) cnt_hi_q <= rx_data;
            if (lat_cnt_lo_w) rem_q    <= count_w;
            else if (wr_word_w) rem_q  <= rem_q - 16'd1;
            if (lat_dat_hi_w) dat_hi_q <= rx_data;

            if (frame_start_w)   addr_q <= '0;
            else if (rom_load_q) addr_q <= addr_q + 15'd1;

            rom_load_q <= wr_word_w;
            if (wr_word_w) begin
                rom_addr_q <= addr_q;
                rom_data_q <= {dat_hi_q, rx_data};
            end

            if (frame_start_w)  nak_q <= 1'b0;
            else if (nak_set_w) nak_q <= 1'b1;

            new_tx_q <= resp_fire_w;
            if (resp_fire_w) tx_data_q <= nak_q ? NAK_BYTE : ACK_BYTE;

            if (frame_start_w) begin
                cpu_rst_q  <= 1'b1;
                loaded_q   <= 1'b0;
                load_err_q <= 1'b0;
            end else if (resp_fire_w) begin
                cpu_rst_q  <= 1'b0;
                loaded_q   <= !nak_q;
                load_err_q <= nak_q;
            end
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)                sum_q <= '0;
        else if (frame_start_w) sum_q <= '0;
        else if (add_sum_w)     sum_q <= sum_q + rx_data;
    end
`endif

    assign tx_data           = tx_data_q;
    assign new_tx_data       = new_tx_q;
    assign ROMAddressLineCtl = rom_addr_q;
    assign ROMDataLine       = rom_data_q;
    assign ROMLoad           = rom_load_q;
    assign cpu_rst           = cpu_rst_q;
    assign loaded            = loaded_q;
    assign load_err          = load_err_q;

endmodule
